// File: rtl/bit_sparsity_pkg.sv
// Shared types for the bit-sparsity encoder/decoder pair: token layout and decoder states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bit_sparsity_pkg;

    localparam int ACT_W   = 8;
    localparam int PLACE_W = 3;

    // Bit-place token as it travels through the bit-places FIFO.
    typedef struct packed {
        logic               last;
        logic               empty;
        logic [PLACE_W-1:0] place;
    } token_t;

    typedef enum logic {
        S_ACCUM,
        S_EMIT
    } state_t;

endpackage

// File: rtl/bit_place_order_checker.sv
// Flags token streams that break encoder order: places must strictly descend, and an
// EMPTY token may only appear alone as the single LAST token of a value.
// Latency: combinational error pulse in the cycle the offending token is consumed; no backpressure.
// Ports: clk, rst (sync, active-high), consume (token popped this cycle), token {last, empty, place},
//        err (one-cycle pulse on a violation).
module bit_place_order_checker
    import bit_sparsity_pkg::*;
#(
    parameter int PLACE_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               consume,
    input  logic [PLACE_W+1:0] token,
    output logic               err
);

    logic               tok_last;
    logic               tok_empty;
    logic [PLACE_W-1:0] tok_place;

    // in_value: at least one token of the current value has already been consumed.
    logic               in_value;
    logic [PLACE_W-1:0] prev_place;

    assign tok_last  = token[PLACE_W+1];
    assign tok_empty = token[PLACE_W];
    assign tok_place = token[PLACE_W-1:0];

    always_comb begin
        err = 1'b0;
        if (consume) begin
            if (in_value) begin
                // Mid-value: EMPTY is never legal, and places must keep strictly descending.
                err = tok_empty | (tok_place >= prev_place);
            end else begin
                // First token: EMPTY is only legal when it closes the value on its own.
                err = tok_empty & ~tok_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_value   <= 1'b0;
            prev_place <= '0;
        end else if (consume) begin
            in_value   <= ~tok_last;
            prev_place <= tok_place;
        end
    end

endmodule

// File: rtl/bit_places_to_value_decoder.sv
// Rebuilds activation values from {LAST, EMPTY, PLACE} bit-place tokens and pushes them to a values FIFO.
// Latency: push one cycle after the LAST token is popped; one value per (tokens+1) cycles.
// Backpressure: while the values FIFO is full the value is held stable and no tokens are popped.
// Ports: CLK, RSTN (sync, active-high); PlaceFIFOReadReady/ReadData/ReadEnable (FWFT token FIFO);
//        ValueFIFOWriteReady/WriteEnable/WriteData (values FIFO); ValueCount (pushes since reset, wraps);
//        DecodeError (sticky order-violation flag, only live when BIT_DECODER_ORDER_CHECK_EN is defined).
module bit_places_to_value_decoder
    import bit_sparsity_pkg::*;
#(
    parameter int DATA_W  = ACT_W,
    parameter int PLACE_W = 3,
    parameter int CNT_W   = 16
) (
    input  logic               CLK,
    input  logic               RSTN,
    input  logic               PlaceFIFOReadReady,
    input  logic [PLACE_W+1:0] PlaceFIFOReadData,
    output logic               PlaceFIFOReadEnable,
    input  logic               ValueFIFOWriteReady,
    output logic               ValueFIFOWriteEnable,
    output logic [DATA_W-1:0]  ValueFIFOWriteData,
    output logic [CNT_W-1:0]   ValueCount,
    output logic               DecodeError
);

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   acc, acc_nxt;
    logic                out_valid, out_valid_nxt;
    logic [DATA_W-1:0]   wdata_nxt;

    logic                tok_last;
    logic                tok_empty;
    logic [PLACE_W-1:0]  tok_place;
    logic [DATA_W-1:0]   place_bit;
    logic [DATA_W-1:0]   merged;
    logic                pop;
    logic                push;

    assign tok_last  = PlaceFIFOReadData[PLACE_W+1];
    assign tok_empty = PlaceFIFOReadData[PLACE_W];
    assign tok_place = PlaceFIFOReadData[PLACE_W-1:0];

    assign place_bit = {{(DATA_W-1){1'b0}}, 1'b1} << tok_place;
    // EMPTY contributes nothing; re-setting an already set place is harmless under OR.
    assign merged    = acc | (tok_empty ? {DATA_W{1'b0}} : place_bit);

    // Both strobes are suppressed while reset is held so no FIFO entry is lost or duplicated.
    assign pop  = (state == S_ACCUM) & PlaceFIFOReadReady & ~RSTN;
    assign push = (state == S_EMIT) & out_valid & ValueFIFOWriteReady & ~RSTN;

    assign PlaceFIFOReadEnable  = pop;
    assign ValueFIFOWriteEnable = push;

    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        out_valid_nxt = out_valid;
        wdata_nxt     = ValueFIFOWriteData;
        case (state)
            S_ACCUM: begin
                if (pop) begin
                    if (tok_last) begin
                        wdata_nxt     = merged;
                        out_valid_nxt = 1'b1;
                        acc_nxt       = '0;
                        state_nxt     = S_EMIT;
                    end else begin
                        acc_nxt = merged;
                    end
                end
            end
            S_EMIT: begin
                if (push) begin
                    out_valid_nxt = 1'b0;
                    state_nxt     = S_ACCUM;
                end
            end
            default: state_nxt = S_ACCUM;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RSTN) begin
            state              <= S_ACCUM;
            acc                <= '0;
            out_valid          <= 1'b0;
            ValueFIFOWriteData <= '0;
            ValueCount         <= '0;
        end else begin
            state              <= state_nxt;
            acc                <= acc_nxt;
            out_valid          <= out_valid_nxt;
            ValueFIFOWriteData <= wdata_nxt;
            if (push) begin
                ValueCount <= ValueCount + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

`ifdef BIT_DECODER_ORDER_CHECK_EN
    logic err_pulse;
    logic err_q;

    bit_place_order_checker #(
        .PLACE_W (PLACE_W)
    ) u_order_checker (
        .clk     (CLK),
        .rst     (RSTN),
        .consume (pop),
        .token   (PlaceFIFOReadData),
        .err     (err_pulse)
    );

    // Sticky until reset; decoding itself is never altered by an order violation.
    always_ff @(posedge CLK) begin
        if (RSTN) begin
            err_q <= 1'b0;
        end else if (err_pulse) begin
            err_q <= 1'b1;
        end
    end

    assign DecodeError = err_q;
`else
    assign DecodeError = 1'b0;
`endif

endmodule

// File: tb/tb_bit_places_to_value_decoder.sv
module tb_bit_places_to_value_decoder;

`ifdef BIT_DECODER_ORDER_CHECK_EN
    localparam bit EXP_ERR = 1'b1;
`else
    localparam bit EXP_ERR = 1'b0;
`endif

    logic        CLK  = 1'b0;
    logic        RSTN = 1'b1;
    logic        rd_rdy = 1'b0;
    logic [4:0]  rd_dat = 5'd0;
    logic        rd_en;
    logic        wr_rdy = 1'b0;
    logic        wr_en;
    logic [7:0]  wr_dat;
    logic [15:0] vcnt;
    logic        derr;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    logic [4:0] tq[$];           // bit-places FIFO contents (head = FWFT data)
    logic [7:0] oq[$];           // values pushed by the DUT
    int         push_cyc[$];
    int         last_pop_cyc[$];

    always #5 CLK = ~CLK;

    bit_places_to_value_decoder dut (
        .CLK                  (CLK),
        .RSTN                 (RSTN),
        .PlaceFIFOReadReady   (rd_rdy),
        .PlaceFIFOReadData    (rd_dat),
        .PlaceFIFOReadEnable  (rd_en),
        .ValueFIFOWriteReady  (wr_rdy),
        .ValueFIFOWriteEnable (wr_en),
        .ValueFIFOWriteData   (wr_dat),
        .ValueCount           (vcnt),
        .DecodeError          (derr)
    );

    // FIFO models: pops and pushes take effect on the rising edge.
    always @(posedge CLK) begin
        cyc++;
        if (rd_en && tq.size() != 0) begin
            if (rd_dat[4]) last_pop_cyc.push_back(cyc);
            void'(tq.pop_front());
        end
        if (wr_en) begin
            oq.push_back(wr_dat);
            push_cyc.push_back(cyc);
        end
    end

    always @(negedge CLK) begin
        rd_rdy = (tq.size() != 0);
        rd_dat = (tq.size() != 0) ? tq[0] : 5'd0;
    end

    function automatic logic [4:0] tok(input bit last, input bit empty, input int p);
        return {last, empty, 3'(p)};
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        RSTN = 1'b1;
        #1;
        tq.delete(); oq.delete(); push_cyc.delete(); last_pop_cyc.delete();
        repeat (2) @(negedge CLK);
        RSTN = 1'b0;
    endtask

    task automatic wait_out(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (oq.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic encode(input logic [7:0] v);
        int lo;
        if (v == 8'd0) begin
            tq.push_back(tok(1, 1, 0));
        end else begin
            lo = 0;
            for (int p = 7; p >= 0; p--) if (v[p]) lo = p;
            for (int p = 7; p >= 0; p--) if (v[p]) tq.push_back(tok(p == lo, 0, p));
        end
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RSTN = 1'b1;
        #1 tq.push_back(tok(1, 0, 3));
        repeat (2) @(negedge CLK);
        nvec++; if (rd_en !== 1'b0) begin nerr++; $display("FAIL rst_rd_en: got %b want 0", rd_en); end
        nvec++; if (wr_en !== 1'b0) begin nerr++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
        nvec++; if (wr_dat !== 8'h00) begin nerr++; $display("FAIL rst_wr_dat: got %h want 00", wr_dat); end
        nvec++; if (vcnt !== 16'd0) begin nerr++; $display("FAIL rst_count: got %0d want 0", vcnt); end
        nvec++; if (derr !== 1'b0) begin nerr++; $display("FAIL rst_derr: got %b want 0", derr); end
        RSTN = 1'b0;
        #1;
        nvec++; if (rd_en !== 1'b1) begin nerr++; $display("FAIL post_rst_rd_en: got %b want 1", rd_en); end
    endtask

    task automatic test_value_a5();
        bit ok;
        do_reset();
        wr_rdy = 1'b1;
        #1;
        tq.push_back(tok(0, 0, 7)); tq.push_back(tok(0, 0, 5));
        tq.push_back(tok(0, 0, 2)); tq.push_back(tok(1, 0, 0));
        wait_out(1, ok);
        nvec++; if (!ok) begin nerr++; $display("FAIL a5_timeout: got 0 pushes want 1"); end
        if (ok) begin
            nvec++; if (oq[0] !== 8'hA5) begin nerr++; $display("FAIL a5_value: got %h want a5", oq[0]); end
            nvec++; if (push_cyc[0] - last_pop_cyc[0] != 1) begin
                nerr++; $display("FAIL a5_latency: got %0d want 1", push_cyc[0] - last_pop_cyc[0]);
            end
        end
        nvec++; if (vcnt !== 16'd1) begin nerr++; $display("FAIL a5_count: got %0d want 1", vcnt); end
        repeat (3) @(negedge CLK);
        nvec++; if (oq.size() != 1) begin nerr++; $display("FAIL a5_single_push: got %0d want 1", oq.size()); end
    endtask

    task automatic test_zero_and_msb();
        bit ok;
        do_reset();
        wr_rdy = 1'b1;
        #1;
        tq.push_back(tok(1, 1, 0));
        tq.push_back(tok(1, 0, 7));
        wait_out(2, ok);
        nvec++; if (!ok) begin nerr++; $display("FAIL zero_timeout: got %0d pushes want 2", oq.size()); end
        if (ok) begin
            nvec++; if (oq[0] !== 8'h00) begin nerr++; $display("FAIL zero_value: got %h want 00", oq[0]); end
            nvec++; if (oq[1] !== 8'h80) begin nerr++; $display("FAIL msb_value: got %h want 80", oq[1]); end
        end
        nvec++; if (vcnt !== 16'd2) begin nerr++; $display("FAIL zero_count: got %0d want 2", vcnt); end
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        wr_rdy = 1'b0;
        #1;
        tq.push_back(tok(0, 0, 1)); tq.push_back(tok(1, 0, 0));
        tq.push_back(tok(1, 0, 4));
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (tq.size() == 1) begin ok = 1'b1; break; end
        end
        nvec++; if (!ok) begin nerr++; $display("FAIL bp_timeout: got %0d tokens left want 1", tq.size()); end
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            nvec++; if (wr_en !== 1'b0) begin nerr++; $display("FAIL bp_wr_en[%0d]: got %b want 0", i, wr_en); end
            nvec++; if (wr_dat !== 8'h03) begin nerr++; $display("FAIL bp_hold[%0d]: got %h want 03", i, wr_dat); end
            nvec++; if (tq.size() != 1) begin nerr++; $display("FAIL bp_no_pop[%0d]: got %0d want 1", i, tq.size()); end
        end
        wr_rdy = 1'b1;
        #1;
        nvec++; if (wr_en !== 1'b1) begin nerr++; $display("FAIL bp_release: got %b want 1", wr_en); end
        wait_out(2, ok);
        nvec++; if (!ok) begin nerr++; $display("FAIL bp_drain: got %0d pushes want 2", oq.size()); end
        if (ok) begin
            nvec++; if (oq[0] !== 8'h03) begin nerr++; $display("FAIL bp_value0: got %h want 03", oq[0]); end
            nvec++; if (oq[1] !== 8'h10) begin nerr++; $display("FAIL bp_value1: got %h want 10", oq[1]); end
            nvec++; if (last_pop_cyc[1] != push_cyc[0] + 1) begin
                nerr++; $display("FAIL bp_next_pop: got cycle %0d want %0d", last_pop_cyc[1], push_cyc[0] + 1);
            end
        end
    endtask

    task automatic test_reset_mid_value();
        bit ok;
        do_reset();
        wr_rdy = 1'b1;
        #1;
        tq.push_back(tok(0, 0, 6)); tq.push_back(tok(0, 0, 4));
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (tq.size() == 0) begin ok = 1'b1; break; end
        end
        nvec++; if (!ok) begin nerr++; $display("FAIL midrst_timeout: got %0d tokens left want 0", tq.size()); end
        RSTN = 1'b1;
        @(negedge CLK);
        RSTN = 1'b0;
        #1 tq.push_back(tok(1, 0, 1));
        wait_out(1, ok);
        nvec++; if (!ok) begin nerr++; $display("FAIL midrst_push: got 0 pushes want 1"); end
        if (ok) begin
            nvec++; if (oq[0] !== 8'h02) begin nerr++; $display("FAIL midrst_value: got %h want 02", oq[0]); end
        end
        nvec++; if (vcnt !== 16'd1) begin nerr++; $display("FAIL midrst_count: got %0d want 1", vcnt); end
    endtask

    task automatic test_order_check();
        bit ok;
        do_reset();
        wr_rdy = 1'b1;
        #1;
        tq.push_back(tok(0, 0, 2)); tq.push_back(tok(1, 0, 5));
        wait_out(1, ok);
        nvec++; if (!ok) begin nerr++; $display("FAIL order_push: got 0 pushes want 1"); end
        if (ok) begin
            nvec++; if (oq[0] !== 8'h24) begin nerr++; $display("FAIL order_value: got %h want 24", oq[0]); end
        end
        nvec++; if (derr !== EXP_ERR) begin nerr++; $display("FAIL order_err: got %b want %b", derr, EXP_ERR); end
        #1 tq.push_back(tok(1, 0, 0));
        wait_out(2, ok);
        nvec++; if (!ok) begin nerr++; $display("FAIL order_push2: got %0d pushes want 2", oq.size()); end
        if (ok) begin
            nvec++; if (oq[1] !== 8'h01) begin nerr++; $display("FAIL order_value2: got %h want 01", oq[1]); end
        end
        nvec++; if (derr !== EXP_ERR) begin nerr++; $display("FAIL order_sticky: got %b want %b", derr, EXP_ERR); end
    endtask

    task automatic test_loopback();
        logic [7:0] vals[100];
        bit ok;
        do_reset();
        vals[0] = 8'h00;
        vals[1] = 8'hFF;
        for (int i = 2; i < 100; i++) vals[i] = 8'($urandom_range(0, 255));
        #1;
        for (int i = 0; i < 100; i++) encode(vals[i]);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge CLK);
            wr_rdy = ($urandom_range(0, 3) != 0);
            if (oq.size() == 100) begin ok = 1'b1; break; end
        end
        wr_rdy = 1'b1;
        nvec++; if (!ok) begin nerr++; $display("FAIL loop_timeout: got %0d values want 100", oq.size()); end
        if (ok) begin
            for (int i = 0; i < 100; i++) begin
                nvec++; if (oq[i] !== vals[i]) begin nerr++; $display("FAIL loop_value[%0d]: got %h want %h", i, oq[i], vals[i]); end
            end
        end
        @(negedge CLK);
        nvec++; if (vcnt !== 16'd100) begin nerr++; $display("FAIL loop_count: got %0d want 100", vcnt); end
        nvec++; if (derr !== 1'b0) begin nerr++; $display("FAIL loop_err: got %b want 0", derr); end
    endtask

    initial begin
        test_reset();
        test_value_a5();
        test_zero_and_msb();
        test_backpressure();
        test_reset_mid_value();
        test_order_check();
        test_loopback();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/bit_places_to_value_decoder.md
Name: bit_places_to_value_decoder

Overview:
- Inverse of the activation bit-sparsity encoder. Pops bit-place tokens from the bit-places FIFO and rebuilds each 8-bit activation value by OR-ing one-hot bits. Pushes each rebuilt value into a values FIFO.
- Sits on the consumer side of the bit-serial datapath. It is used for loop-back checks and for rebuilding activations after bit-sparse processing.
- Token format (shared with the encoder): {LAST, EMPTY, PLACE[2:0]}.
  - EMPTY=1 marks a zero-valued activation and sets no bit.
  - LAST=1 closes the value.

Parameters:
- DATA_W, 8, activation value width.
- PLACE_W, 3, bit-place index width; must equal clog2(DATA_W).
- CNT_W, 16, width of the emitted-value counter.

Ports:
- CLK  in  1  clock; all logic is on the rising edge.
- RSTN  in  1  reset, synchronous, active-high.
- PlaceFIFOReadReady  in  1  bit-places FIFO is non-empty. The FIFO is first-word-fall-through, so data is valid while this is high.
- PlaceFIFOReadData  in  PLACE_W+2  token {LAST, EMPTY, PLACE}.
- PlaceFIFOReadEnable  out  1  pop strobe.
- ValueFIFOWriteReady  in  1  values FIFO is not full.
- ValueFIFOWriteEnable  out  1  push strobe.
- ValueFIFOWriteData  out  DATA_W  rebuilt value.
- ValueCount  out  CNT_W  number of values pushed since reset; wraps at 2^CNT_W.
- DecodeError  out  1  sticky error flag (optional feature only).

Behaviour:
- Reset values: state=S_ACCUM, accumulator=0, out_valid=0, ValueFIFOWriteData=0, ValueCount=0, DecodeError=0. PlaceFIFOReadEnable and ValueFIFOWriteEnable are both 0 during reset.
- Reset mid-operation discards any partial accumulator and any pending output.
- PlaceFIFOReadEnable = (state==S_ACCUM) & PlaceFIFOReadReady & ~RSTN. This is combinational; a token is consumed in the same cycle its strobe is high.
- On a consumed token:
  - next_acc = acc | (EMPTY ? 0 : 1<<PLACE).
  - If LAST=0: acc <= next_acc.
  - If LAST=1: ValueFIFOWriteData <= next_acc, out_valid <= 1, acc <= 0, state <= S_EMIT.
- S_EMIT:
  - ValueFIFOWriteEnable = out_valid & ValueFIFOWriteReady, combinational.
  - When that push occurs: out_valid <= 0, ValueCount += 1, state <= S_ACCUM.
  - No tokens are popped in S_EMIT.
- Latency: LAST token popped in cycle N → push in cycle N+1 at the earliest. Back-pressure holds the push, with data stable, until ValueFIFOWriteReady=1.
- Throughput: one value per (tokens+1) cycles.
- Setting a place that is already set is idempotent, because the OR operation simply repeats.
- Token arriving when the values FIFO is full: the decoder stays in S_EMIT, and the token remains in its FIFO and is not lost.
- PlaceFIFOReadReady=0 in S_ACCUM: the accumulator holds and there are no strobes.
- A non-last token with EMPTY=1 adds nothing to the value.

Optional Feature:
- Macro: BIT_DECODER_ORDER_CHECK_EN.
- When defined, each value's token stream is checked. It must follow the encoder order: strictly descending PLACE values, with EMPTY allowed only as a single token carrying LAST=1.
- On any violation (repeated or ascending place, EMPTY mixed with places, non-last EMPTY):
  - DecodeError <= 1, sticky until reset.
  - Decoding continues unchanged.
- When undefined, DecodeError is tied to 0 and no ordering state is kept.

Decomposition:
- Package bit_sparsity_pkg holds:
  - localparams ACT_W=8 and PLACE_W=3;
  - a typedef for the token struct {last, empty, place};
  - a state enum {S_ACCUM, S_EMIT}.
- One sub-module, bit_place_order_checker, generated only under the macro. Inputs: token + consume strobe. Output: error pulse.

Test Plan:
- Value 0xA5: tokens (7),(5),(2),(0,LAST) with write always ready → one push of 0xA5 on the cycle after the LAST pop; ValueCount=1.
- Zero value: single token (EMPTY,LAST) → push of 0x00. Then 0x80 as single token (7,LAST) → push of 0x80; ValueCount=2.
- Back-pressure: ValueFIFOWriteReady=0 for 5 cycles after the LAST of 0x03 → no pops, data held at 0x03, push on the first ready cycle. The next value's tokens are popped only after that push.
- Reset mid-value: pop (6),(4), then assert RSTN for one cycle, then send (1,LAST) → push of 0x02, not 0x52; ValueCount=1.
- Order check (macro on): tokens (2),(5,LAST) → push 0x24 and DecodeError=1 afterward. Then valid 0x01 → push 0x01 with the error still 1. With the macro off, the same stimulus gives DecodeError=0.
- Stream of 100 random values through the encoder→decoder loop-back → output sequence equals input sequence and ValueCount=100.
